// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder front end.
// Raw A/B inputs pass through a two-flop synchroniser and a glitch filter
// before Gray-sequence decoding. The decoder emits a one-cycle count pulse
// with a direction level, reports illegal two-bit transitions, and keeps a
// saturating error count.
// Optional macro QUAD_INDEX_EN adds the quad_z input and the index_pulse
// output. Z is filtered like A/B and pulses once on each filtered rising edge.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter bit          FWD        = 1'b1,
  parameter bit          X4         = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       quad_a,
  input  logic       quad_b,
`ifdef QUAD_INDEX_EN
  input  logic       quad_z,
`endif
  input  logic       err_clr,
  output logic       pulse_out,
  output logic       dir_out,
  output logic       err_pulse,
`ifdef QUAD_INDEX_EN
  output logic       index_pulse,
`endif
  output logic [7:0] err_count
);

  // Channel map: bit 0 = B, bit 1 = A, bit 2 = Z (only when the index is built)
`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  typedef enum logic [0:0] {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_prime_cnt;
  logic             w_prime;
  logic             w_run;

  logic [NCH-1:0]   w_raw;
  logic [NCH-1:0]   w_filt;

  logic [1:0]       r_prev;
  logic [1:0]       w_cur;
  logic [1:0]       w_diff;
  logic             w_step;
  logic             w_illegal;
  logic             w_fwd;
  logic             w_count;

  logic             r_pulse;
  logic             r_dir;
  logic             r_err;
  logic [7:0]       r_err_cnt;

`ifdef QUAD_INDEX_EN
  assign w_raw = {quad_z, quad_a, quad_b};
`else
  assign w_raw = {quad_a, quad_b};
`endif

  // State register. PRIME runs for four cycles (counter 0..3).
  // That is long enough for a resting non-00 level to pass through both
  // synchroniser flops, the filtered value and prev before decoding starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_PRIME;
      r_prime_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_prime_cnt <= (r_state == ST_PRIME) ? r_prime_cnt + 2'd1 : 2'd0;
    end
  end

  // Next-state logic: leave PRIME once the prime counter has reached 3
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_PRIME && r_prime_cnt == 2'd3) begin
      w_state_next = ST_RUN;
    end
  end

  // FSM outputs: mode strobes used by the filters and the decoder
  always_comb begin
    w_prime = (r_state == ST_PRIME);
    w_run   = (r_state == ST_RUN);
  end

  // Per-channel synchroniser and glitch filter
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic       r_meta;
    logic       r_sync;
    logic       r_filt;
    logic [7:0] r_cnt;
    logic [8:0] w_cnt_inc;

    assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
    assign w_filt[gi] = r_filt;

    // The filtered value follows sync once it has differed for FILTER_LEN
    // consecutive cycles. During PRIME it loads directly.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
        r_filt <= 1'b0;
        r_cnt  <= 8'd0;
      end else begin
        r_meta <= w_raw[gi];
        r_sync <= r_meta;
        if (w_prime) begin
          r_filt <= r_sync;
          r_cnt  <= 8'd0;
        end else if (r_sync == r_filt) begin
          r_cnt  <= 8'd0;
        end else if (w_cnt_inc == 9'(FILTER_LEN)) begin
          r_filt <= r_sync;
          r_cnt  <= 8'd0;
        end else begin
          r_cnt  <= w_cnt_inc[7:0];
        end
      end
    end
  end

  // Gray decode of the filtered A/B pair against the previous pair.
  // Forward sequence is 00 -> 10 -> 11 -> 01 -> 00.
  always_comb begin
    w_cur     = {w_filt[1], w_filt[0]};
    w_diff    = w_cur ^ r_prev;
    w_step    = ^w_diff;
    w_illegal = &w_diff;
    w_fwd     = 1'b0;
    case (r_prev)
      2'b00:   w_fwd = (w_cur == 2'b10);
      2'b10:   w_fwd = (w_cur == 2'b11);
      2'b11:   w_fwd = (w_cur == 2'b01);
      default: w_fwd = (w_cur == 2'b00);
    endcase
    if (X4) begin
      w_count = w_step;
    end else begin
      w_count = (r_prev == 2'b00 && w_cur == 2'b10) ||
                (r_prev == 2'b10 && w_cur == 2'b00);
    end
  end

  // Registered pulse, direction and error outputs.
  // Direction still tracks while en is low; only the pulse is suppressed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev    <= 2'b00;
      r_pulse   <= 1'b0;
      r_dir     <= FWD;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_prev  <= w_cur;
      r_pulse <= 1'b0;
      r_err   <= 1'b0;
      if (w_run && w_count) begin
        r_pulse <= en;
        r_dir   <= w_fwd ? FWD : ~FWD;
      end
      if (w_run && w_illegal) begin
        r_err <= 1'b1;
      end
      if (err_clr) begin
        r_err_cnt <= 8'd0;
      end else if (w_run && w_illegal && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

`ifdef QUAD_INDEX_EN
  logic r_z_prev;
  logic r_index;

  // Index pulse on each filtered rising edge of Z, only in RUN with en high
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_z_prev <= 1'b0;
      r_index  <= 1'b0;
    end else begin
      r_z_prev <= w_filt[2];
      r_index  <= w_run & en & w_filt[2] & ~r_z_prev;
    end
  end

  assign index_pulse = r_index;
`endif

  assign pulse_out = r_pulse;
  assign dir_out   = r_dir;
  assign err_pulse = r_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed test of quad_decoder with FILTER_LEN=4 and FWD=1.
// Two instances share the same stimulus: one in x4 mode and one in x1 mode.
module tb_quad_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic       quad_a;
  logic       quad_b;
  logic       err_clr;
  logic       p4, d4, e4;
  logic       p1, d1, e1;
  logic [7:0] c4, c1;
`ifdef QUAD_INDEX_EN
  logic       quad_z;
  logic       idx4, idx1;
`endif

  quad_decoder #(.FILTER_LEN(4), .FWD(1'b1), .X4(1'b1)) u_dut_x4 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
`ifdef QUAD_INDEX_EN
    .quad_z     (quad_z),
    .index_pulse(idx4),
`endif
    .err_clr    (err_clr),
    .pulse_out  (p4),
    .dir_out    (d4),
    .err_pulse  (e4),
    .err_count  (c4)
  );

  quad_decoder #(.FILTER_LEN(4), .FWD(1'b1), .X4(1'b0)) u_dut_x1 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
`ifdef QUAD_INDEX_EN
    .quad_z     (quad_z),
    .index_pulse(idx1),
`endif
    .err_clr    (err_clr),
    .pulse_out  (p1),
    .dir_out    (d1),
    .err_pulse  (e1),
    .err_count  (c1)
  );

  // Edge counter used to measure pulse latency
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the falling edge
  int unsigned n_p4 = 0, n_p1 = 0, n_e4 = 0, n_e1 = 0;
  int unsigned n_back = 0;
  int unsigned last_p4_cyc = 0;
  logic p4_d = 1'b0, p1_d = 1'b0, e4_d = 1'b0, e1_d = 1'b0;
  always @(negedge clk) begin
    if (p4 === 1'b1) begin
      n_p4 = n_p4 + 1;
      last_p4_cyc = cyc;
      if (p4_d) n_back = n_back + 1;
    end
    if (p1 === 1'b1) begin
      n_p1 = n_p1 + 1;
      if (p1_d) n_back = n_back + 1;
    end
    if (e4 === 1'b1) begin
      n_e4 = n_e4 + 1;
      if (e4_d) n_back = n_back + 1;
    end
    if (e1 === 1'b1) begin
      n_e1 = n_e1 + 1;
      if (e1_d) n_back = n_back + 1;
    end
    p4_d = (p4 === 1'b1);
    p1_d = (p1 === 1'b1);
    e4_d = (e4 === 1'b1);
    e1_d = (e1 === 1'b1);
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("vec %s ok (%0d)", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0]  fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0]  rev_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  int unsigned c0, b4, b1, be4, be1;

  initial begin
    reset = 1'b0; en = 1'b1; quad_a = 1'b1; quad_b = 1'b1; err_clr = 1'b0;
`ifdef QUAD_INDEX_EN
    quad_z = 1'b0;
`endif
    step(5);
    check_vec("rst_pulse", p4, 0);
    check_vec("rst_err", e4, 0);
    check_vec("rst_errcnt", c4, 0);
    check_vec("rst_dir", d4, 1);
    check_vec("rst_dir_x1", d1, 1);

    // Release reset while resting at 11: priming must hide the level
    reset = 1'b1;
    step(20);
    check_vec("prime11_pulses", n_p4 + n_p1, 0);
    check_vec("prime11_errs", n_e4 + n_e1, 0);
    check_vec("prime11_dir", d4, 1);

    // Re-reset at 00 for the sequence tests
    {quad_a, quad_b} = 2'b00; reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(10);

    // Forward cycle: x4 pulses on each step 7 edges after the drive
    b1 = n_p1;
    for (int i = 0; i < 4; i++) begin
      {quad_a, quad_b} = fwd_seq[i];
      c0 = cyc; b4 = n_p4;
      step(10);
      check_vec("fwd_cnt", n_p4 - b4, 1);
      check_vec("fwd_lat", last_p4_cyc - c0, 7);
      check_vec("fwd_dir", d4, 1);
    end
    check_vec("fwd_x1_cnt", n_p1 - b1, 1);
    check_vec("fwd_x1_dir", d1, 1);

    // Reverse cycle: x1 stays silent until 10->00
    b1 = n_p1;
    for (int i = 0; i < 4; i++) begin
      {quad_a, quad_b} = rev_seq[i];
      b4 = n_p4;
      step(10);
      check_vec("rev_cnt", n_p4 - b4, 1);
      check_vec("rev_dir", d4, 0);
      if (i < 3) begin
        check_vec("rev_x1_silent", n_p1 - b1, 0);
        check_vec("rev_x1_dir_hold", d1, 1);
      end
    end
    check_vec("rev_x1_cnt", n_p1 - b1, 1);
    check_vec("rev_x1_dir", d1, 0);

    // Glitch of 3 cycles is swallowed; a 4-cycle level gets through
    b4 = n_p4; b1 = n_p1; be4 = n_e4;
    quad_a = 1'b1;
    step(3);
    quad_a = 1'b0;
    step(15);
    check_vec("glitch3_pulse", (n_p4 - b4) + (n_p1 - b1), 0);
    check_vec("glitch3_err", n_e4 - be4, 0);
    c0 = cyc;
    quad_a = 1'b1;
    step(12);
    check_vec("glitch4_pulse", n_p4 - b4, 1);
    check_vec("glitch4_lat", last_p4_cyc - c0, 7);
    check_vec("glitch4_dir", d4, 1);
    quad_a = 1'b0;
    step(12);
    check_vec("glitch4_back", n_p4 - b4, 2);
    check_vec("glitch4_back_dir", d4, 0);

    // en=0: direction tracks, pulses suppressed
    en = 1'b0;
    b4 = n_p4; b1 = n_p1;
    for (int i = 0; i < 4; i++) begin
      {quad_a, quad_b} = fwd_seq[i];
      step(10);
    end
    check_vec("en0_pulse", (n_p4 - b4) + (n_p1 - b1), 0);
    check_vec("en0_dir", d4, 1);
    check_vec("en0_dir_x1", d1, 1);
    en = 1'b1;
    {quad_a, quad_b} = 2'b10;
    step(10);
    check_vec("en1_pulse", n_p4 - b4, 1);
    check_vec("en1_pulse_x1", n_p1 - b1, 1);

    // Back to 00 (reverse step), then 300 illegal 00<->11 jumps
    {quad_a, quad_b} = 2'b00;
    step(10);
    b4 = n_p4; b1 = n_p1; be4 = n_e4; be1 = n_e1;
    for (int i = 0; i < 300; i++) begin
      {quad_a, quad_b} = ~{quad_a, quad_b};
      step(8);
    end
    step(5);
    check_vec("err_pulses", n_e4 - be4, 300);
    check_vec("err_pulses_x1", n_e1 - be1, 300);
    check_vec("err_sat", c4, 255);
    check_vec("err_sat_x1", c1, 255);
    check_vec("err_no_pulse", (n_p4 - b4) + (n_p1 - b1), 0);
    check_vec("err_dir_hold", d4, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_vec("err_clr", c4, 0);

    // Clear held across an error: the clear wins
    be4 = n_e4;
    err_clr = 1'b1;
    {quad_a, quad_b} = 2'b11;
    step(10);
    err_clr = 1'b0;
    check_vec("clr_wins_pulse", n_e4 - be4, 1);
    check_vec("clr_wins_cnt", c4, 0);
    {quad_a, quad_b} = 2'b00;
    step(10);
    check_vec("err_after_clr", c4, 1);

    // Reset mid-motion at a non-00 level: quiet re-prime
    b4 = n_p4; be4 = n_e4;
    {quad_a, quad_b} = 2'b10; reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(20);
    check_vec("rerst_pulse", n_p4 - b4, 0);
    check_vec("rerst_err", n_e4 - be4, 0);
    check_vec("rerst_errcnt", c4, 0);
    check_vec("rerst_dir", d4, 1);

    check_vec("one_cycle_pulses", n_back, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
